// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if;
  logic        imem_busywait;
  logic        dmem_busywait;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memRead;
  logic        ex_writeEnable;
  logic        ex_insthit;
  logic        ex_redirect;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        flush_id;
  logic        bubble_ex;
  logic        bubble_wb;
  logic [2:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output imem_busywait, dmem_busywait, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_memRead, ex_writeEnable, ex_insthit, ex_redirect,
    input  stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_wb,
           state, stall_count, flush_count
  );

  modport slave (
    input  imem_busywait, dmem_busywait, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_rd, ex_memRead, ex_writeEnable, ex_insthit, ex_redirect,
    output stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_wb,
           state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls, load-use stalls,
// redirect flushes with fetch draining, and saturating stall/flush counters.
module pipeline_hazard_ctrl (
  input  logic                         clock,
  input  logic                         reset,
  pipeline_hazard_ctrl_if.slave        hz
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    LU_STALL  = 3'd1,
    DMEM_WAIT = 3'd2,
    DRAIN     = 3'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        redirect_pending;
  logic        redirect_now;
  logic        redirect_ev;
  logic        load_use;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        flush_id;
  logic        bubble_ex;
  logic        bubble_wb;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  assign redirect_now = hz.ex_redirect & hz.ex_insthit;
  assign redirect_ev  = redirect_now | redirect_pending;
  assign load_use = hz.ex_insthit & hz.ex_memRead & hz.ex_writeEnable & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // Priority chain: dmem wait > redirect > drain > load-use > imem wait.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    bubble_wb = 1'b0;
    state_d   = RUN;
    if (reset) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      bubble_wb = 1'b1;
    end else if (hz.dmem_busywait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      bubble_wb = 1'b1;
      state_d   = DMEM_WAIT;
    end else if (redirect_ev) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = hz.imem_busywait ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      // The fetch in flight belongs to the wrong path; discard it when it lands.
      flush_id  = 1'b1;
      state_d   = hz.imem_busywait ? DRAIN : RUN;
    end else if (load_use && state_q != LU_STALL) begin
      stall_if  = 1'b1;
      bubble_ex = 1'b1;
      state_d   = LU_STALL;
    end else if (hz.imem_busywait) begin
      stall_if  = 1'b1;
      flush_id  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q          <= RUN;
      redirect_pending <= 1'b0;
      stall_count      <= 16'd0;
      flush_count      <= 16'd0;
    end else begin
      state_q <= state_d;
      // Hold a redirect seen during a data-memory wait; it is applied the cycle the wait ends.
      redirect_pending <= hz.dmem_busywait & (redirect_pending | redirect_now);
      if ((stall_if | stall_id | stall_ex) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if ((flush_id | bubble_ex) && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end

  assign hz.stall_if    = stall_if;
  assign hz.stall_id    = stall_id;
  assign hz.stall_ex    = stall_ex;
  assign hz.flush_id    = flush_id;
  assign hz.bubble_ex   = bubble_ex;
  assign hz.bubble_wb   = bubble_wb;
  assign hz.state       = state_q;
  assign hz.stall_count = stall_count;
  assign hz.flush_count = flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control vector order is
// {stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_wb}.
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       we;
    logic       hit;
    logic       stall;
  } lu_vec_t;

  function automatic logic [5:0] ctl();
    return {hif.stall_if, hif.stall_id, hif.stall_ex, hif.flush_id, hif.bubble_ex, hif.bubble_wb};
  endfunction

  task automatic idle();
    hif.imem_busywait  = 1'b0;
    hif.dmem_busywait  = 1'b0;
    hif.id_rs1         = 5'd0;
    hif.id_rs2         = 5'd0;
    hif.id_use_rs1     = 1'b0;
    hif.id_use_rs2     = 1'b0;
    hif.ex_rd          = 5'd0;
    hif.ex_memRead     = 1'b0;
    hif.ex_writeEnable = 1'b0;
    hif.ex_insthit     = 1'b0;
    hif.ex_redirect    = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    hif.ex_rd          = rd;
    hif.ex_memRead     = 1'b1;
    hif.ex_writeEnable = 1'b1;
    hif.ex_insthit     = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    hif.dmem_busywait = 1'b1;
    hif.imem_busywait = 1'b1;
    hif.ex_redirect   = 1'b1;
    set_load(5'd3);
    hif.id_rs1 = 5'd3; hif.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b000111) begin
      errors++; $display("FAIL reset_outputs: got %b want 000111", ctl());
    end
    next_cycle();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (hif.state !== 3'd0 || hif.stall_count !== 16'd0 || hif.flush_count !== 16'd0) begin
      errors++; $display("FAIL reset_state: state %0d stall %0d flush %0d want 0 0 0",
                         hif.state, hif.stall_count, hif.flush_count);
    end
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL idle_outputs: got %b want 000000", ctl());
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5);
    hif.id_rs2 = 5'd5; hif.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b100010) begin
      errors++; $display("FAIL lu_first: got %b want 100010", ctl());
    end
    next_cycle();
    #1;
    checks++;
    if (hif.state !== 3'd1 || ctl() !== 6'b000000) begin
      errors++; $display("FAIL lu_stall_state: state %0d ctl %b want 1 000000", hif.state, ctl());
    end
    next_cycle();
    idle();
    #1;
    checks++;
    if (hif.state !== 3'd0 || hif.stall_count !== 16'd1 || hif.flush_count !== 16'd1) begin
      errors++; $display("FAIL lu_after: state %0d stall %0d flush %0d want 0 1 1",
                         hif.state, hif.stall_count, hif.flush_count);
    end
  endtask

  task automatic test_load_use_table();
    lu_vec_t vecs [8];
    vecs[0] = {5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = {5'd5, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = {5'd5, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = {5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = {5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = {5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = {5'd0, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = {5'd6, 5'd8, 1'b1, 1'b1, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      hif.id_rs1 = vecs[i].rs1;  hif.id_rs2 = vecs[i].rs2;
      hif.id_use_rs1 = vecs[i].u1; hif.id_use_rs2 = vecs[i].u2;
      hif.ex_rd = vecs[i].rd;    hif.ex_memRead = vecs[i].mr;
      hif.ex_writeEnable = vecs[i].we; hif.ex_insthit = vecs[i].hit;
      #1;
      checks++;
      if (ctl() !== (vecs[i].stall ? 6'b100010 : 6'b000000)) begin
        errors++; $display("FAIL lu_vec%0d_ctl: got %b want stall=%0b", i, ctl(), vecs[i].stall);
      end
      next_cycle();
      checks++;
      if (hif.state !== (vecs[i].stall ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL lu_vec%0d_state: got %0d want %0d", i, hif.state, vecs[i].stall);
      end
    end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    hif.dmem_busywait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl() !== 6'b111001) begin
        errors++; $display("FAIL dmem_cycle%0d: got %b want 111001", i, ctl());
      end
      next_cycle();
    end
    hif.dmem_busywait = 1'b0;
    #1;
    checks++;
    if (hif.state !== 3'd2 || ctl() !== 6'b000000) begin
      errors++; $display("FAIL dmem_exit: state %0d ctl %b want 2 000000", hif.state, ctl());
    end
    next_cycle();
    checks++;
    if (hif.state !== 3'd0 || hif.stall_count !== 16'd4 || hif.flush_count !== 16'd0) begin
      errors++; $display("FAIL dmem_counts: state %0d stall %0d flush %0d want 0 4 0",
                         hif.state, hif.stall_count, hif.flush_count);
    end
  endtask

  task automatic test_redirect_in_wait();
    do_reset();
    hif.dmem_busywait = 1'b1;
    hif.ex_redirect   = 1'b1;
    hif.ex_insthit    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl() !== 6'b111001) begin
        errors++; $display("FAIL rdw_wait%0d: got %b want 111001", i, ctl());
      end
      next_cycle();
      hif.ex_redirect = 1'b0;
      hif.ex_insthit  = 1'b0;
    end
    hif.dmem_busywait = 1'b0;
    #1;
    checks++;
    if (ctl() !== 6'b000110) begin
      errors++; $display("FAIL rdw_apply: got %b want 000110", ctl());
    end
    next_cycle();
    #1;
    checks++;
    if (ctl() !== 6'b000000 || hif.state !== 3'd0) begin
      errors++; $display("FAIL rdw_cleared: ctl %b state %0d want 000000 0", ctl(), hif.state);
    end
  endtask

  task automatic test_redirect_drain();
    logic [5:0] exp_ctl [3];
    logic [2:0] exp_state [3];
    logic       imem [3];
    exp_ctl[0] = 6'b000110; exp_ctl[1] = 6'b000100; exp_ctl[2] = 6'b000100;
    exp_state[0] = 3'd0;    exp_state[1] = 3'd3;    exp_state[2] = 3'd3;
    imem[0] = 1'b1;         imem[1] = 1'b1;         imem[2] = 1'b0;
    do_reset();
    hif.ex_redirect = 1'b1;
    hif.ex_insthit  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hif.imem_busywait = imem[i];
      #1;
      checks++;
      if (ctl() !== exp_ctl[i] || hif.state !== exp_state[i]) begin
        errors++; $display("FAIL drain%0d: ctl %b state %0d want %b %0d",
                           i, ctl(), hif.state, exp_ctl[i], exp_state[i]);
      end
      next_cycle();
      hif.ex_redirect = 1'b0;
      hif.ex_insthit  = 1'b0;
    end
    hif.imem_busywait = 1'b0;
    #1;
    checks++;
    if (hif.state !== 3'd0 || ctl() !== 6'b000000 ||
        hif.flush_count !== 16'd3 || hif.stall_count !== 16'd0) begin
      errors++; $display("FAIL drain_end: state %0d ctl %b flush %0d stall %0d want 0 000000 3 0",
                         hif.state, ctl(), hif.flush_count, hif.stall_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_load(5'd9);
    hif.id_rs1 = 5'd9; hif.id_use_rs1 = 1'b1;
    hif.ex_redirect = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b000110) begin
      errors++; $display("FAIL redirect_over_lu: got %b want 000110", ctl());
    end
    next_cycle();
    checks++;
    if (hif.state !== 3'd0) begin
      errors++; $display("FAIL redirect_over_lu_state: got %0d want 0", hif.state);
    end
    idle();
    hif.ex_redirect = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b000000) begin
      errors++; $display("FAIL redirect_invalid: got %b want 000000", ctl());
    end
    idle();
    hif.imem_busywait = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b100100) begin
      errors++; $display("FAIL imem_only: got %b want 100100", ctl());
    end
    set_load(5'd4);
    hif.id_rs2 = 5'd4; hif.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 6'b100010) begin
      errors++; $display("FAIL lu_over_imem: got %b want 100010", ctl());
    end
    next_cycle();
    #1;
    checks++;
    if (hif.state !== 3'd1 || ctl() !== 6'b100100) begin
      errors++; $display("FAIL lu_stall_imem: state %0d ctl %b want 1 100100", hif.state, ctl());
    end
    next_cycle();
    checks++;
    if (hif.state !== 3'd0) begin
      errors++; $display("FAIL lu_stall_exit: got %0d want 0", hif.state);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hif.dmem_busywait = 1'b1;
    hif.ex_redirect   = 1'b1;
    hif.ex_insthit    = 1'b1;
    next_cycle();
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (hif.state !== 3'd0 || ctl() !== 6'b000000 || hif.stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid_wait: state %0d ctl %b stall %0d want 0 000000 0",
                         hif.state, ctl(), hif.stall_count);
    end
    hif.ex_redirect   = 1'b1;
    hif.ex_insthit    = 1'b1;
    hif.imem_busywait = 1'b1;
    next_cycle();
    checks++;
    if (hif.state !== 3'd3) begin
      errors++; $display("FAIL reset_mid_drain_entry: got %0d want 3", hif.state);
    end
    idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (hif.state !== 3'd0 || ctl() !== 6'b000000 || hif.flush_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid_drain: state %0d ctl %b flush %0d want 0 000000 0",
                         hif.state, ctl(), hif.flush_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    hif.dmem_busywait = 1'b1;
    repeat (65534) @(posedge clock);
    @(negedge clock);
    checks++;
    if (hif.stall_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_near: got %h want fffe", hif.stall_count);
    end
    repeat (70000 - 65534) @(posedge clock);
    @(negedge clock);
    checks++;
    if (hif.stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h want ffff", hif.stall_count);
    end
    do_reset();
    checks++;
    if (hif.stall_count !== 16'd0) begin
      errors++; $display("FAIL sat_reset: got %h want 0000", hif.stall_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_load_use_table();
    test_dmem_wait();
    test_redirect_in_wait();
    test_redirect_drain();
    test_priority();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL: clock  input  1  pipeline clock; all state updates on posedge.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: imem_busywait  input  1  instruction memory not ready this cycle.
REQ-004 SHALL: dmem_busywait  input  1  data memory not ready this cycle.
REQ-005 SHALL: id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL: id_use_rs1, id_use_rs2  input  1 each  ID instruction reads that source.
REQ-007 SHALL: ex_rd  input  5  destination register of the instruction in EX.
REQ-008 SHALL: ex_memRead, ex_writeEnable, ex_insthit  input  1 each  EX control and valid bits.
REQ-009 SHALL: ex_redirect  input  1  taken branch or jump resolved in EX.
REQ-010 SHALL: stall_if  output  1  hold PC and the IF/ID register.
REQ-011 SHALL: stall_id  output  1  hold the ID/EX register.
REQ-012 SHALL: stall_ex  output  1  hold the EX/MEM register.
REQ-013 SHALL: flush_id  output  1  load a bubble (insthit=0) into IF/ID.
REQ-014 SHALL: bubble_ex  output  1  load a bubble (all controls 0) into ID/EX.
REQ-015 SHALL: bubble_wb  output  1  load a bubble (insthit=0) into MEM/WB.
REQ-016 SHALL: state  output  3  current FSM state code.
REQ-017 SHALL: stall_count, flush_count  output  16 each  saturating performance counters.

Function
REQ-018 SHALL: load_use = ex_insthit & ex_memRead & ex_writeEnable & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 SHALL: redirect_ev = ex_redirect & ex_insthit | redirect_pending.
REQ-020 SHALL: states RUN=0, LU_STALL=1, DMEM_WAIT=2, DRAIN=3; outputs are combinational (Mealy) from state and inputs, valid before the next posedge.
REQ-021 SHALL: priority each cycle: dmem_busywait > redirect_ev > load_use > imem_busywait.
REQ-022 SHALL: dmem_busywait=1 (any state) -> stall_if=stall_id=stall_ex=1, bubble_wb=1, flush_id=bubble_ex=0; next state DMEM_WAIT.
REQ-023 SHALL: ex_redirect & ex_insthit while dmem_busywait=1 sets redirect_pending; pending clears in the cycle the redirect is applied.
REQ-024 SHALL: redirect_ev without dmem_busywait -> flush_id=1, bubble_ex=1, stalls 0; next state DRAIN if imem_busywait=1, else RUN.
REQ-025 SHALL: DRAIN -> flush_id=1 each cycle while imem_busywait=1 (discard stale fetch); first cycle with imem_busywait=0 -> flush_id=1, next state RUN.
REQ-026 SHALL: load_use in RUN -> stall_if=1, bubble_ex=1; next state LU_STALL.
REQ-027 SHALL: LU_STALL lasts exactly one cycle; load_use ignored there; next state RUN unless a higher-priority event applies.
REQ-028 SHALL: imem_busywait alone in RUN -> stall_if=1, flush_id=1; downstream stages advance.
REQ-029 SHALL: DMEM_WAIT exits when dmem_busywait=0; that cycle follows REQ-024..028 normally (pending redirect applied first).
REQ-030 SHALL: stall_count +1 per cycle with any stall_* =1; flush_count +1 per cycle with flush_id or bubble_ex =1; both saturate at 16'hFFFF, no wrap.
REQ-031 SHALL: redirect simultaneous with load_use -> redirect wins; no LU_STALL entered.

Reset
REQ-032 SHALL: reset=1 at posedge -> state RUN, redirect_pending=0, stall_count=flush_count=0.
REQ-033 SHALL: while reset=1, outputs flush_id=bubble_ex=bubble_wb=1, stall_if=stall_id=stall_ex=0, regardless of other inputs.
REQ-034 SHALL: reset mid-DMEM_WAIT or mid-DRAIN discards all pending state; first cycle after reset is RUN.

Verification
REQ-035 SHALL: load x5 in EX (ex_memRead=1, ex_rd=5), ID reads rs2=5 -> one cycle stall_if=1, bubble_ex=1, state 1, then RUN; stall_count=1.
REQ-036 SHALL: ex_rd=0 with matching rs1=0 load -> no stall, state stays 0.
REQ-037 SHALL: dmem_busywait high 4 cycles -> stall_if/id/ex and bubble_wb high 4 cycles, stall_count=4.
REQ-038 SHALL: ex_redirect during dmem_busywait (3 cycles) -> no flush during wait; flush_id=bubble_ex=1 on first cycle after wait.
REQ-039 SHALL: redirect with imem_busywait high 2 more cycles -> flush_id high 3 cycles total, state DRAIN then RUN.
REQ-040 SHALL: 70000 consecutive stall cycles -> stall_count reads 16'hFFFF; reset -> 0.
